alu_writeback_pipe: RTL
=======================

Name: alu_writeback_pipe

Overview:
- Execute/write-back end of the pipelined processor; consumes the per-instruction control outputs of the control unit (alu_control, write) together with register addresses and an immediate.
- Three stages:
  - S1: operand read from an internal register file, with forwarding.
  - S2: ALU execute into the WB register.
  - S3: register-file write-back.
- Exposes the write-back bus and a debug read port for verification.

Parameters:
- DATA_W, 8, datapath and register width.
- AW, 3, register address width; NREG = 2**AW entries.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction present this cycle.
- alu_control  input  2  ALU op: 00 add, 01 sub, 10 and, 11 or.
- write  input  1  instruction writes rd at write-back.
- use_imm  input  1  operand B = imm instead of R[rs2].
- rs1  input  AW  source A address.
- rs2  input  AW  source B address.
- rd  input  AW  destination address.
- imm  input  DATA_W  immediate operand.
- flush  input  1  synchronous kill of the S2 instruction.
- wb_valid  output  1  WB-stage instruction valid.
- wb_we  output  1  register file written at the next edge.
- wb_addr  output  AW  WB destination.
- wb_data  output  DATA_W  WB result.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  DATA_W  combinational R[dbg_addr].

Behaviour:
- Reset (async, active-high):
  - Clears all S2/WB pipeline registers and every register-file entry to 0.
  - wb_valid=0, wb_we=0, wb_addr=0, wb_data=0.
  - An in-flight instruction is discarded; no write occurs at the edge following reset release unless new instructions are issued.
- R0 reads as 0 at all times; writes to R0 are ignored (wb_we forced 0 when wb_addr==0).
- S1 (combinational, cycle N):
  - Operand A = fwd(rs1).
  - Operand B = use_imm ? imm : fwd(rs2).
  - fwd(a) priority:
    1. a==0 → 0.
    2. S2 valid & write & S2.rd==a → S2 ALU result.
    3. WB valid & write & wb_addr==a → wb_data.
    4. Otherwise regfile[a].
- Edge E0 (end of cycle N): S2 register latches valid=in_valid, op, write, rd, operands.
- Cycle N+1:
  - ALU is combinational on S2.
  - add/sub wrap modulo 2**DATA_W; no carry or flags.
- Edge E1: WB register latches valid, write, rd, result. wb_* outputs become visible in cycle N+2.
  - wb_we = wb_valid & write & (wb_addr!=0).
- Edge E2: regfile[wb_addr] <= wb_data when wb_we.
- Latency: issue to wb_data = 2 cycles; issue to architectural update = 3 edges. Throughput is 1 instruction/cycle; no stalls are needed, since forwarding covers all RAW distances.
- flush: at the next edge the WB register receives valid=0, killing the S2 instruction. S1 issue in the same cycle is still accepted into S2.
- Bubbles: in_valid=0 latches valid=0. Other S2 fields are don't-care but held stable (no toggling) to ease waveform reading.
- dbg_data reads the committed regfile only, with no forwarding.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU op constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - DATA_W and AW defaults.
  - The S2/WB stage-record field layout.
- One sub-module: reg_file, NREG x DATA_W:
  - 2 combinational read ports plus a debug read port.
  - 1 synchronous write port.
  - Async reset to zero.
  - R0 hardwired zero.
- ALU and forwarding muxes stay in the top module.

Test Plan:
- Reset then immediate load: issue add R1=R0+imm 0x05 (use_imm, write) → wb_valid=1, wb_addr=1, wb_data=0x05 two cycles later; dbg R1=0x05 after the third edge.
- Back-to-back RAW: R1=5, then next cycle R2=R1+imm 3, then R3=R2 sub R1 → wb_data sequence 0x05, 0x08, 0x03 on consecutive cycles (EX and WB forwarding paths).
- Wrap and logic: R4=0xFF via imm, R5=R4+imm 0x02 → 0x01; R6=R4 and imm 0x0F → 0x0F; R7=R0 or imm 0xA0 → 0xA0.
- R0 protection: issue write to rd=0 with result 0x33 → wb_valid=1, wb_we=0; dbg R0 stays 0x00.
- Flush: issue R1=0x11, assert flush in the next cycle → no wb_valid for it; R1 keeps its old value. An instruction issued in the flush cycle completes normally.
- Reset mid-flight: issue 2 writes, assert reset asynchronously between edges → wb_* drop to 0 immediately; after release, all registers read 0 and no stale write occurs.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the execute/write-back pipe: ALU opcodes, default widths,
// and the S2 / WB stage-record layouts.
package pipe_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int AW_DEF     = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_e;

    // Execute-stage record: decoded control plus already-forwarded operands.
    typedef struct packed {
        alu_op_e               op;
        logic                  write;
        logic [AW_DEF-1:0]     rd;
        logic [DATA_W_DEF-1:0] a;
        logic [DATA_W_DEF-1:0] b;
    } s2_rec_t;

    typedef struct packed {
        logic                  write;
        logic [AW_DEF-1:0]     rd;
        logic [DATA_W_DEF-1:0] data;
    } wb_rec_t;

endpackage

// File: rtl/alu_writeback_pipe_if.sv
// Issue, write-back and debug-read bus of the execute/write-back pipe.
// master drives instructions and observes write-back; slave is the pipe.
interface alu_writeback_pipe_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
);
    logic              in_valid;
    logic [1:0]        alu_control;
    logic              write;
    logic              use_imm;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] imm;
    logic              flush;

    logic              wb_valid;
    logic              wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output in_valid, alu_control, write, use_imm, rs1, rs2, rd, imm, flush,
        output dbg_addr,
        input  wb_valid, wb_we, wb_addr, wb_data,
        input  dbg_data
    );

    modport slave (
        input  in_valid, alu_control, write, use_imm, rs1, rs2, rd, imm, flush,
        input  dbg_addr,
        output wb_valid, wb_we, wb_addr, wb_data,
        output dbg_data
    );

endinterface

// File: rtl/alu_writeback_pipe_reg_file.sv
// NREG x DATA_W register file: two combinational read ports, a debug read
// port and one synchronous write port. Entry 0 is hardwired to zero.
module reg_file
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra_addr,
    input  logic [AW-1:0]     rb_addr,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);
    localparam int NREG = 2**AW;

    logic [DATA_W-1:0] mem [NREG];

    assign mem[0] = '0;

    for (genvar i = 1; i < NREG; i++) begin : g_ent
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                mem[i] <= '0;
            else if (we && waddr == AW'(i))
                mem[i] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_writeback_pipe.sv
// Execute/write-back pipe: S1 forwarded operand read, S2 ALU execute,
// WB register-file commit. One instruction per cycle, no stalls.
module alu_writeback_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = AW_DEF
) (
    input  logic                clk,
    input  logic                reset,
    alu_writeback_pipe_if.slave bus
);
    localparam int STAGES = 1;

    // vld_pipe[0] = S2 valid, vld_pipe[STAGES] = WB valid
    logic [STAGES:0]   vld_pipe;
    s2_rec_t           s2;
    wb_rec_t           wb;
    logic              wb_we;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_res;

    reg_file #(.DATA_W(DATA_W), .AW(AW)) u_rf (
        .clk      (clk),
        .reset    (reset),
        .ra_addr  (bus.rs1),
        .rb_addr  (bus.rs2),
        .dbg_addr (bus.dbg_addr),
        .ra_data  (rf_a),
        .rb_data  (rf_b),
        .dbg_data (bus.dbg_data),
        .we       (wb_we),
        .waddr    (wb.rd),
        .wdata    (wb.data)
    );

    // Youngest producer wins: S2 result, then WB result, then committed state.
    function automatic logic [DATA_W-1:0] fwd(input logic [AW-1:0]     a,
                                              input logic [DATA_W-1:0] rf_val);
        if (a == '0)
            return '0;
        if (vld_pipe[0] && s2.write && s2.rd == a)
            return alu_res;
        if (vld_pipe[STAGES] && wb.write && wb.rd == a)
            return wb.data;
        return rf_val;
    endfunction

    always_comb begin
        op_a = fwd(bus.rs1, rf_a);
        op_b = bus.use_imm ? bus.imm : fwd(bus.rs2, rf_b);
    end

    always_comb begin
        alu_res = '0;
        case (s2.op)
            OP_ADD:  alu_res = s2.a + s2.b;
            OP_SUB:  alu_res = s2.a - s2.b;
            OP_AND:  alu_res = s2.a & s2.b;
            OP_OR:   alu_res = s2.a | s2.b;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s2       <= '0;
            wb       <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0] & {STAGES{~bus.flush}}, bus.in_valid};
            // Bubbles and flushed slots leave the record fields untouched.
            if (bus.in_valid)
                s2 <= '{op:    alu_op_e'(bus.alu_control),
                        write: bus.write,
                        rd:    bus.rd,
                        a:     op_a,
                        b:     op_b};
            if (vld_pipe[0] && !bus.flush)
                wb <= '{write: s2.write, rd: s2.rd, data: alu_res};
        end
    end

    assign wb_we        = vld_pipe[STAGES] & wb.write & (wb.rd != '0);
    assign bus.wb_valid = vld_pipe[STAGES];
    assign bus.wb_we    = wb_we;
    assign bus.wb_addr  = wb.rd;
    assign bus.wb_data  = wb.data;

endmodule
